// File: rtl/ws_conv_sequencer_pkg.sv
// Shared types and helpers for the weight-stationary convolution sequencer.
package ws_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_W_FETCH,
        S_W_LOAD,
        S_W_SETTLE,
        S_EXEC,
        S_DRAIN,
        S_PAUSE,
        S_DONE
    } state_t;

    // Coarse phase grouping, handy when probing the sequencer in debug mode.
    typedef enum logic [1:0] {
        PH_WEIGHT,
        PH_SETTLE,
        PH_EXEC,
        PH_DRAIN
    } phase_t;

    function automatic logic [31:0] psum_base(input logic [31:0] kij, input logic [31:0] nij);
        return kij * nij;
    endfunction

endpackage

// File: rtl/ws_conv_sequencer_sram_rd_pipe.sv
// SRAM read-issue throttle with a one-cycle valid pipeline that drives the L0 write strobe.
module sram_rd_pipe (
    input  logic clk,
    input  logic reset,
    input  logic req_i,
    input  logic l0_afull_i,
    output logic issue_o,
    output logic l0_wr_o
);

    logic pend_q;

    // When L0 is almost full only one read may be outstanding.
    assign issue_o = req_i && (!l0_afull_i || !pend_q);
    assign l0_wr_o = pend_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            pend_q <= 1'b0;
        end else begin
            pend_q <= issue_o;
        end
    end

endmodule

// File: rtl/ws_conv_sequencer.sv
// Layer-level sequencer: weight fetch/load, activation streaming and psum drain per kernel position.
module ws_conv_sequencer
    import ws_seq_pkg::*;
#(
    parameter int row    = 8,
    parameter int col    = 8,
    parameter int ADDR_W = 11,
    parameter int CNT_W  = 11
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              debug_mode,
    input  logic [CNT_W-1:0]  num_nij,
    input  logic [CNT_W-1:0]  num_kij,
    input  logic [ADDR_W-1:0] weight_start_addr,
    input  logic [ADDR_W-1:0] act_start_addr,
    output logic              sram_cen,
    output logic [ADDR_W-1:0] sram_addr,
    output logic              l0_wr,
    output logic              l0_rd,
    input  logic              l0_afull,
    input  logic              l0_empty,
    output logic              array_load,
    output logic              array_exec,
    input  logic              ofifo_valid,
    output logic              ofifo_rd,
    output logic              psum_wen,
    output logic [ADDR_W-1:0] psum_addr,
    output logic              busy,
    output logic              done
);

    state_t state_q, state_d, resume_q, resume_d, phase_next;
    logic              start_q, start_dly_q, start_edge;
    logic [CNT_W-1:0]  nij_q, nij_d, nkij_q, nkij_d, kij_q, kij_d;
    logic [CNT_W-1:0]  icnt_q, icnt_d, lcnt_q, lcnt_d, pcnt_q, pcnt_d;
    logic [ADDR_W-1:0] wbase_q, wbase_d, abase_q, abase_d, rd_addr;
    logic              rd_req, rd_issue, phase_end, drain_en;

    sram_rd_pipe u_rd_pipe (
        .clk        (clk),
        .reset      (reset),
        .req_i      (rd_req),
        .l0_afull_i (l0_afull),
        .issue_o    (rd_issue),
        .l0_wr_o    (l0_wr)
    );

    assign start_edge = start_q && !start_dly_q;
    assign sram_cen   = rd_issue;
    assign sram_addr  = rd_issue ? rd_addr : '0;
    assign busy       = (state_q != S_IDLE) && (state_q != S_DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            resume_q    <= S_IDLE;
            start_q     <= 1'b0;
            start_dly_q <= 1'b0;
            nij_q       <= '0;
            nkij_q      <= '0;
            kij_q       <= '0;
            icnt_q      <= '0;
            lcnt_q      <= '0;
            pcnt_q      <= '0;
            wbase_q     <= '0;
            abase_q     <= '0;
        end else begin
            state_q     <= state_d;
            resume_q    <= resume_d;
            start_q     <= start;
            start_dly_q <= start_q;
            nij_q       <= nij_d;
            nkij_q      <= nkij_d;
            kij_q       <= kij_d;
            icnt_q      <= icnt_d;
            lcnt_q      <= lcnt_d;
            pcnt_q      <= pcnt_d;
            wbase_q     <= wbase_d;
            abase_q     <= abase_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        resume_d   = resume_q;
        nij_d      = nij_q;
        nkij_d     = nkij_q;
        kij_d      = kij_q;
        icnt_d     = icnt_q;
        lcnt_d     = lcnt_q;
        pcnt_d     = pcnt_q;
        wbase_d    = wbase_q;
        abase_d    = abase_q;
        rd_req     = 1'b0;
        rd_addr    = '0;
        phase_end  = 1'b0;
        phase_next = S_IDLE;
        drain_en   = 1'b0;
        l0_rd      = 1'b0;
        array_load = 1'b0;
        array_exec = 1'b0;
        ofifo_rd   = 1'b0;
        psum_wen   = 1'b0;
        psum_addr  = '0;
        done       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_edge) begin
                    if (num_kij == '0 || num_nij == '0) begin
                        state_d = S_DONE;
                    end else begin
                        nij_d   = num_nij;
                        nkij_d  = num_kij;
                        wbase_d = weight_start_addr;
                        abase_d = act_start_addr;
                        kij_d   = '0;
                        icnt_d  = '0;
                        lcnt_d  = '0;
                        pcnt_d  = '0;
                        state_d = S_W_FETCH;
                    end
                end
            end
            S_W_FETCH: begin
                // icnt counts issued reads, lcnt counts rows landed in L0.
                rd_req  = icnt_q < CNT_W'(row);
                rd_addr = wbase_q + ADDR_W'(32'(kij_q) * row + 32'(icnt_q));
                if (rd_issue) icnt_d = icnt_q + CNT_W'(1);
                if (l0_wr) begin
                    lcnt_d = lcnt_q + CNT_W'(1);
                    if (lcnt_q == CNT_W'(row - 1)) begin
                        icnt_d     = '0;
                        lcnt_d     = '0;
                        phase_end  = 1'b1;
                        phase_next = S_W_LOAD;
                    end
                end
            end
            S_W_LOAD: begin
                l0_rd      = 1'b1;
                array_load = 1'b1;
                lcnt_d     = lcnt_q + CNT_W'(1);
                if (lcnt_q == CNT_W'(row - 1)) begin
                    lcnt_d  = '0;
                    state_d = S_W_SETTLE;
                end
            end
            S_W_SETTLE: begin
                lcnt_d = lcnt_q + CNT_W'(1);
                if (lcnt_q == CNT_W'(row + col - 1)) begin
                    lcnt_d     = '0;
                    phase_end  = 1'b1;
                    phase_next = S_EXEC;
                end
            end
            S_EXEC: begin
                drain_en = 1'b1;
                rd_req   = icnt_q < nij_q;
                rd_addr  = abase_q + ADDR_W'(icnt_q);
                if (rd_issue) icnt_d = icnt_q + CNT_W'(1);
                if (!l0_empty && lcnt_q < nij_q) begin
                    l0_rd      = 1'b1;
                    array_exec = 1'b1;
                    lcnt_d     = lcnt_q + CNT_W'(1);
                    if (lcnt_q == nij_q - CNT_W'(1)) begin
                        icnt_d     = '0;
                        lcnt_d     = '0;
                        phase_end  = 1'b1;
                        phase_next = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                drain_en = 1'b1;
                if (pcnt_q == nij_q) begin
                    pcnt_d     = '0;
                    kij_d      = kij_q + CNT_W'(1);
                    phase_end  = 1'b1;
                    phase_next = (kij_q + CNT_W'(1) == nkij_q) ? S_DONE : S_W_FETCH;
                end
            end
            S_PAUSE: begin
                if (start_edge) state_d = resume_q;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (phase_end) begin
            if (debug_mode) begin
                state_d  = S_PAUSE;
                resume_d = phase_next;
            end else begin
                state_d = phase_next;
            end
        end

        if (drain_en && ofifo_valid && pcnt_q < nij_q) begin
            ofifo_rd  = 1'b1;
            psum_wen  = 1'b1;
            psum_addr = ADDR_W'(psum_base(32'(kij_q), 32'(nij_q))) + ADDR_W'(pcnt_q);
            pcnt_d    = pcnt_q + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_ws_conv_sequencer.sv
// Self-checking bench: L0/OFIFO environment models plus an address-sequence reference model.
module tb_ws_conv_sequencer;

    localparam int ROW = 8, COL = 8, AW = 11, CW = 11, L0_DEPTH = 16, AMASK = 2047;

    logic          clk = 1'b0;
    logic          reset, start, debug_mode;
    logic [CW-1:0] num_nij, num_kij;
    logic [AW-1:0] weight_start_addr, act_start_addr;
    logic          sram_cen, l0_wr, l0_rd, l0_afull, l0_empty, array_load, array_exec;
    logic          ofifo_valid, ofifo_rd, psum_wen, busy, done;
    logic [AW-1:0] sram_addr, psum_addr;

    always #5 clk = ~clk;

    ws_conv_sequencer #(.row(ROW), .col(COL), .ADDR_W(AW), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .start(start), .debug_mode(debug_mode),
        .num_nij(num_nij), .num_kij(num_kij),
        .weight_start_addr(weight_start_addr), .act_start_addr(act_start_addr),
        .sram_cen(sram_cen), .sram_addr(sram_addr), .l0_wr(l0_wr), .l0_rd(l0_rd),
        .l0_afull(l0_afull), .l0_empty(l0_empty), .array_load(array_load), .array_exec(array_exec),
        .ofifo_valid(ofifo_valid), .ofifo_rd(ofifo_rd), .psum_wen(psum_wen), .psum_addr(psum_addr),
        .busy(busy), .done(done)
    );

    int          n_chk = 0, n_bad = 0;
    int unsigned cyc = 0;
    int          exp_rd[$], exp_ps[$], of_q[$];
    int          n_cen, n_wen, n_load, n_exec, n_done, quiet = 0, load_run = 0, l0_cnt = 0;
    int          of_lat = 3;
    bit          force_afull = 0, rand_afull = 0, cen_prev = 0;
    bit          wr_e, rd_e, ex_e, ofr_e, rst_e, cen_s, strobes;

    function automatic void chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Environment (L0 occupancy, OFIFO latency) and per-cycle compare process.
    initial begin
        l0_afull = 0; l0_empty = 1; ofifo_valid = 0;
        forever begin
            @(negedge clk);
            rst_e = reset;
            if (!reset) begin
                if (sram_cen) begin
                    n_cen++;
                    if (exp_rd.size() == 0) chk("rd_extra", 1, 0);
                    else chk("rd_addr", sram_addr, exp_rd.pop_front());
                    if (l0_afull) chk("rd_throttle", cen_prev, 0);
                end
                chk("l0_wr_pipe", l0_wr, cen_prev);
                if (l0_wr) chk("l0_overflow", (l0_cnt + 1 - int'(l0_rd)) <= L0_DEPTH, 1);
                chk("wen_eq_ofifo_rd", psum_wen, ofifo_rd);
                if (psum_wen) begin
                    n_wen++;
                    chk("ofifo_rd_valid", ofifo_valid, 1);
                    if (exp_ps.size() == 0) chk("ps_extra", 1, 0);
                    else chk("ps_addr", psum_addr, exp_ps.pop_front());
                end
                if (l0_rd) begin
                    chk("l0_rd_nonempty", l0_empty, 0);
                    chk("instr_excl", array_load & array_exec, 0);
                end
                chk("l0_rd_instr", l0_rd, array_load | array_exec);
                if (array_load) begin
                    n_load++; load_run++;
                end else begin
                    if (load_run != 0) chk("load_len", load_run, ROW);
                    load_run = 0;
                end
                if (array_exec) n_exec++;
                if (done) begin
                    n_done++;
                    chk("done_not_busy", busy, 0);
                end
                strobes = sram_cen | l0_wr | l0_rd | array_load | array_exec | ofifo_rd | psum_wen;
                if (!busy) chk("idle_quiet", strobes, 0);
                quiet = (busy && !strobes) ? quiet + 1 : 0;
            end
            wr_e = l0_wr; rd_e = l0_rd; ex_e = array_exec; ofr_e = ofifo_rd; cen_s = sram_cen;
            @(posedge clk); #1;
            cyc++;
            if (rst_e) begin
                l0_cnt = 0; of_q.delete(); cen_prev = 0; quiet = 0; load_run = 0;
            end else begin
                l0_cnt = l0_cnt + int'(wr_e) - int'(rd_e);
                if (ex_e) of_q.push_back(int'(cyc) - 1 + of_lat);
                if (ofr_e && of_q.size() != 0) void'(of_q.pop_front());
                cen_prev = cen_s;
            end
            l0_empty    = (l0_cnt == 0);
            l0_afull    = force_afull || l0_cnt >= L0_DEPTH - 1 || (rand_afull && $urandom_range(3) == 0);
            ofifo_valid = of_q.size() > 0 && of_q[0] <= int'(cyc);
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic build(input int nij, input int nkij, input int wb, input int ab);
        exp_rd.delete(); exp_ps.delete();
        for (int k = 0; k < nkij; k++) begin
            for (int r = 0; r < ROW; r++) exp_rd.push_back((wb + k * ROW + r) & AMASK);
            for (int n = 0; n < nij; n++) exp_rd.push_back((ab + n) & AMASK);
            for (int p = 0; p < nij; p++) exp_ps.push_back((k * nij + p) & AMASK);
        end
        n_cen = 0; n_wen = 0; n_load = 0; n_exec = 0; n_done = 0;
    endtask

    task automatic start_run(input int nij, input int nkij, input int wb, input int ab, input bit dbg);
        build(nij, nkij, wb, ab);
        num_nij = CW'(nij); num_kij = CW'(nkij);
        weight_start_addr = AW'(wb); act_start_addr = AW'(ab);
        debug_mode = dbg;
        start = 1;
        step(3);
        // Config is latched by now; scramble it to show it is not re-read.
        num_nij = CW'($urandom); num_kij = CW'($urandom);
        weight_start_addr = AW'($urandom); act_start_addr = AW'($urandom);
    endtask

    task automatic finish_run(input int nij, input int nkij, input int exp_pauses);
        int pauses = 0;
        for (int i = 0; i < 20000 && n_done == 0; i++) begin
            step();
            if (quiet >= 22) begin
                pauses++;
                start = 0; step(2); start = 1; step(4);
            end
        end
        chk("done_seen", n_done != 0, 1);
        step(3);
        chk("pauses", pauses, exp_pauses);
        chk("done_count", n_done, 1);
        chk("busy_after", busy, 0);
        chk("rd_left", exp_rd.size(), 0);
        chk("ps_left", exp_ps.size(), 0);
        chk("n_cen", n_cen, nkij * (ROW + nij));
        chk("n_wen", n_wen, nkij * nij);
        chk("n_load", n_load, nkij * ROW);
        chk("n_exec", n_exec, nkij * nij);
        start = 0; debug_mode = 0;
        step(3);
    endtask

    initial begin
        reset = 1; start = 0; debug_mode = 0;
        num_nij = '0; num_kij = '0; weight_start_addr = '0; act_start_addr = '0;
        step(3);
        reset = 0;
        @(negedge clk);
        chk("reset_outputs", {sram_cen, sram_addr, l0_wr, l0_rd, array_load, array_exec,
                              ofifo_rd, psum_wen, psum_addr, busy, done}, 0);
        step(2);

        // Full layer, then the model pinned against hand-computed addresses.
        build(36, 9, 0, 64);
        chk("pin_rd_size", exp_rd.size(), 396);
        chk("pin_rd_k1_w0", exp_rd[44], 8);
        chk("pin_rd_k8_w0", exp_rd[352], 64);
        chk("pin_rd_last", exp_rd[395], 99);
        chk("pin_ps_last", exp_ps[323], 323);
        start_run(36, 9, 0, 64, 0);
        finish_run(36, 9, 0);

        // Debug mode: four pauses per kernel position.
        start_run(36, 9, 0, 64, 1);
        finish_run(36, 9, 36);

        // L0 almost-full held for 5 cycles mid-EXEC.
        start_run(36, 2, 0, 64, 0);
        for (int i = 0; i < 5000 && n_exec < 10; i++) step();
        force_afull = 1; step(5); force_afull = 0;
        finish_run(36, 2, 0);

        // Empty layer: done two cycles after the start edge, no traffic.
        for (int t = 0; t < 2; t++) begin
            build(0, 0, 0, 0);
            num_nij = (t == 0) ? CW'(36) : CW'(0);
            num_kij = (t == 0) ? CW'(0) : CW'(3);
            start = 1;
            @(negedge clk); chk("empty_done_c0", done, 0);
            step(); @(negedge clk); chk("empty_done_c1", done, 0);
            step(); @(negedge clk); chk("empty_done_c2", done, 1);
            chk("empty_busy", busy, 0);
            step(); @(negedge clk); chk("empty_done_c3", done, 0);
            chk("empty_cen", n_cen, 0);
            chk("empty_wen", n_wen, 0);
            start = 0; step(3);
        end

        // Reset during kij=3 EXEC, then a fresh run from psum address 0.
        start_run(36, 9, 0, 64, 0);
        for (int i = 0; i < 5000 && n_exec < 3 * 36 + 10; i++) step();
        reset = 1; start = 0;
        step();
        reset = 0;
        @(negedge clk);
        chk("reset_mid_outputs", {sram_cen, sram_addr, l0_wr, l0_rd, array_load, array_exec,
                                  ofifo_rd, psum_wen, psum_addr, busy, done}, 0);
        step(3);
        start_run(36, 3, 0, 64, 0);
        finish_run(36, 3, 0);

        // Second start edge during kij=1 W_LOAD is ignored.
        start_run(36, 3, 0, 64, 0);
        for (int i = 0; i < 5000 && n_load < ROW + 2; i++) step();
        start = 0; step(2); start = 1;
        finish_run(36, 3, 0);

        // Randomised configs, OFIFO latency and L0 back-pressure, including address wrap.
        rand_afull = 1;
        for (int it = 0; it < 4; it++) begin
            int nij, nkij, wb, ab;
            bit dbg;
            nij  = (it == 1) ? 1 : int'($urandom_range(1, 20));
            nkij = int'($urandom_range(1, 4));
            wb   = (it == 0) ? 2044 : int'($urandom_range(2047));
            ab   = (it == 0) ? 2040 : int'($urandom_range(2047));
            dbg  = bit'($urandom_range(1));
            of_lat = int'($urandom_range(1, 6));
            start_run(nij, nkij, wb, ab, dbg);
            finish_run(nij, nkij, dbg ? 4 * nkij : 0);
        end
        rand_afull = 0;

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/ws_conv_sequencer.md
Name: ws_conv_sequencer

Overview:
Top-level sequencer for the weight-stationary corelet: on one start it runs a full convolution layer over num_kij kernel positions. Per kij it moves weights from activation/weight SRAM to L0, loads them into the MAC array, streams num_nij activation rows through L0 into the array, and drains OFIFO psums into psum SRAM at kij*num_nij+nij. It sits in core between the inst decoder and the SRAM/L0/MAC-array/OFIFO controls; the host owns SRAM only while busy=0.

Parameters:
row, 8, MAC array rows = input channels per SRAM word
col, 8, MAC array columns = output channels
ADDR_W, 11, SRAM and psum-memory address width
CNT_W, 11, width of nij/kij counters

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
start  in  1  level; rising edge (registered) starts a run, or resumes when paused
debug_mode  in  1  pause after every phase until the next start edge
num_nij  in  CNT_W  activation rows per kij; sampled at start
num_kij  in  CNT_W  kernel positions; sampled at start
weight_start_addr  in  ADDR_W  base of weight rows
act_start_addr  in  ADDR_W  base of activation rows
sram_cen  out  1  SRAM read enable (read data valid next cycle)
sram_addr  out  ADDR_W  SRAM read address
l0_wr  out  1  write SRAM read data into L0
l0_rd  out  1  pop L0 into array
l0_afull  in  1  L0 has at most one free entry
l0_empty  in  1  L0 empty
array_load  out  1  array instruction: shift weights in
array_exec  out  1  array instruction: execute
ofifo_valid  in  1  OFIFO holds a complete psum row
ofifo_rd  out  1  pop OFIFO
psum_wen  out  1  psum SRAM write
psum_addr  out  ADDR_W  psum SRAM write address
busy  out  1  run in progress (including paused)
done  out  1  one-cycle pulse at run completion

Behaviour:
- Reset: state IDLE, all counters 0; every output 0.
- States: IDLE, W_FETCH, W_LOAD, W_SETTLE, EXEC, DRAIN, PAUSE, DONE.
- IDLE: start edge with num_kij==0 or num_nij==0 -> DONE (no transactions); otherwise latch config, kij=0 -> W_FETCH. busy=1 from the cycle after the edge.
- W_FETCH: issue row reads at weight_start_addr+kij*row+r, r=0..row-1, one per cycle, throttled by the read-issue rule. l0_wr = read-pending flag delayed one cycle. Exit when all row writes have landed.
- Read-issue rule (all phases): issue only when !l0_afull, or when l0_afull and no read is in flight.
- W_LOAD: l0_rd=array_load=1 for exactly row cycles.
- W_SETTLE: all array controls low for row+col cycles -> EXEC.
- EXEC: activation reads at act_start_addr+n, n=0..num_nij-1, under the read-issue rule. l0_rd=array_exec=1 whenever !l0_empty. Exit when num_nij rows have popped -> DRAIN.
- Drain path (active in EXEC and DRAIN): ofifo_valid -> ofifo_rd=psum_wen=1 same cycle; psum_addr=kij*num_nij+p with p=0..num_nij-1.
- DRAIN exit: p==num_nij. Then kij++; if kij==num_kij -> DONE, else -> W_FETCH.
- Address arithmetic: wraps modulo 2^ADDR_W with no overflow flag.
- debug_mode=1: at the end of W_FETCH, W_SETTLE, EXEC and DRAIN enter PAUSE (busy stays 1, all strobes 0). Next start edge resumes at the following phase.
- DONE: done=1 for one cycle, busy=0 -> IDLE.
- start edge while busy and not paused: ignored.
- Reset mid-run: next cycle IDLE, outputs 0; in-flight SRAM data dropped (l0_wr not asserted).
- Config changes while busy: ignored (latched values used).

Decomposition:
- Package ws_seq_pkg: state enum, phase encoding for debug visibility, helper function psum_base(kij,num_nij).
- Sub-module sram_rd_pipe: read-issue throttle plus 1-cycle valid pipeline producing l0_wr. Instantiated once and shared by W_FETCH and EXEC.

Test Plan:
- num_nij=36, num_kij=9, weight_start=0, act_start=64, L0 never afull, OFIFO valid 3 cycles after each exec:
  - 9×8 weight reads at addrs 0..71 in kij order;
  - 9×36 activation reads at 64..99;
  - 324 psum writes at addrs 0..323 in order;
  - single done pulse, then busy=0.
- debug_mode=1, same config: exactly 4 pauses per kij (36 total); no strobes while paused; identical address sequence to test 1.
- l0_afull held high for 5 cycles mid-EXEC: at most one outstanding read; no l0_wr while full and pending; all 36 activation rows still delivered in order.
- num_kij=0: done pulses 2 cycles after the start edge; zero sram_cen/psum_wen cycles.
- reset asserted during kij=3 EXEC: next cycle all outputs 0, state IDLE; a fresh start reruns from psum_addr 0.
- Second start edge during kij=1 W_LOAD (debug_mode=0): no effect on sequence or counts.
